// File: rtl/gemm_pipe_nxn.sv
// gemm_pipe_nxn: three-stage valid/ready pipelined N x N matrix multiply, C = A*B (+D),
// with a global stall whenever the result register is full and not being consumed.
module gemm_pipe_nxn #(
    parameter int N     = 2,
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_add_d,
    input  logic [N*N*WIDTH-1:0]   A,
    input  logic [N*N*WIDTH-1:0]   B,
    input  logic [N*N*WIDTH-1:0]   D,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [N*N*WIDTH-1:0]   out
);
    localparam int LATENCY = 3;
    localparam int E = N*N*WIDTH;
    localparam int P = N*N*N*WIDTH;

    logic [LATENCY-1:0] v_q, v_d;
    logic [E-1:0]       a_q, a_d, b_q, b_d, d1_q, d1_d, d2_q, d2_d, c_q, c_d;
    logic [P-1:0]       prod_q, prod_d;
    logic               add1_q, add1_d, add2_q, add2_d;
    logic               accept, ld2, ld3;
    logic [WIDTH-1:0]   sum;

    // in_ready is exactly "not stalled", so it doubles as the pipeline advance enable
    assign in_ready  = ~v_q[LATENCY-1] | out_ready;
    assign accept    = in_valid & in_ready;
    assign ld2       = in_ready & v_q[0];
    assign ld3       = in_ready & v_q[1];
    assign out_valid = v_q[LATENCY-1];
    assign out       = c_q;

    always_comb begin
        v_d    = in_ready ? {v_q[LATENCY-2:0], accept} : v_q;
        a_d    = accept ? A : a_q;
        b_d    = accept ? B : b_q;
        d1_d   = accept ? D : d1_q;
        add1_d = accept ? in_add_d : add1_q;
        d2_d   = ld2 ? d1_q : d2_q;
        add2_d = ld2 ? add1_q : add2_q;
        prod_d = prod_q;
        c_d    = c_q;
        sum    = '0;
        if (ld2)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++)
                    for (int k = 0; k < N; k++)
                        prod_d[((i*N+j)*N+k)*WIDTH +: WIDTH] =
                            a_q[(i*N+k)*WIDTH +: WIDTH] * b_q[(k*N+j)*WIDTH +: WIDTH];
        // bubbles never overwrite S3, so out keeps the last real result
        if (ld3)
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    sum = add2_q ? d2_q[(i*N+j)*WIDTH +: WIDTH] : '0;
                    for (int k = 0; k < N; k++)
                        sum = sum + prod_q[((i*N+j)*N+k)*WIDTH +: WIDTH];
                    c_d[(i*N+j)*WIDTH +: WIDTH] = sum;
                end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v_q    <= '0;
            a_q    <= '0;
            b_q    <= '0;
            d1_q   <= '0;
            add1_q <= 1'b0;
            d2_q   <= '0;
            add2_q <= 1'b0;
            prod_q <= '0;
            c_q    <= '0;
        end else begin
            v_q    <= v_d;
            a_q    <= a_d;
            b_q    <= b_d;
            d1_q   <= d1_d;
            add1_q <= add1_d;
            d2_q   <= d2_d;
            add2_q <= add2_d;
            prod_q <= prod_d;
            c_q    <= c_d;
        end
    end
endmodule

// File: doc/gemm_pipe_nxn.md
Name: gemm_pipe_nxn

Overview:
- Parametrised, fully pipelined N x N matrix-multiply block: computes C = A*B (+ optional bias matrix D) on flattened row-major operand buses.
- Adds valid/ready handshaking with global backpressure stall, a per-transaction bias-add mode, and a configurable element width.
- Sits between operand-fetch logic and the result writeback stream of the generated GEMM kernels.
- Issues one matrix product per cycle when not stalled.

Parameters:
- N, 2, matrix dimension (rows = cols = inner dimension); legal range 1..8.
- WIDTH, 32, element width in bits for A, B, D and C.
- LATENCY, 3, fixed pipeline depth in accepted-to-valid cycles. Informational localparam, not overridable.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept an operand set this cycle.
- in_add_d  in  1  when 1, add D to the product for this transaction.
- A  in  N*N*WIDTH  matrix A. Element [i][j] occupies bits (i*N+j)*WIDTH +: WIDTH.
- B  in  N*N*WIDTH  matrix B, same packing as A.
- D  in  N*N*WIDTH  bias matrix, same packing; ignored when in_add_d=0.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- out  out  N*N*WIDTH  result C, same packing as A.

Behaviour:
- Handshake:
  - Input accepted when in_valid & in_ready.
  - Output consumed when out_valid & out_ready.
  - in_ready = !out_valid | out_ready (combinational).
  - A, B, D and in_add_d are sampled only on acceptance.
- Pipeline, three register stages, each with a valid bit v1..v3:
  - S1 registers A, B, D and the add_d flag.
  - S2 registers all N^3 products A[i][k]*B[k][j], each truncated to WIDTH bits.
  - S3 registers C[i][j] = sum over k of the S2 products, plus D[i][j] if add_d. The sum is truncated mod 2^WIDTH, unsigned and wrap-around, with no saturation.
  - out is driven from the S3 registers and out_valid = v3.
- Stall:
  - stall = v3 & !out_ready.
  - While stalled, every stage register and valid bit holds its value and no input is accepted.
  - There is no bubble compression: a bubble inside the pipe stays in place during a stall.
- Latency:
  - Without stalls, a transaction accepted on edge t presents out_valid=1 immediately after edge t+2, i.e. 3 edges including the accepting edge.
  - Throughput is 1 per cycle and ordering is strictly FIFO.
  - Capacity is 3 in-flight transactions.
- Products: only the low WIDTH bits are kept. Signed and unsigned operands give identical results under this truncation, so the block has no sign mode.
- Reset (rst=1, asynchronous):
  - v1..v3 := 0 and all data registers := 0.
  - Hence out_valid=0 and out=0 immediately, without waiting for a clock edge, and in_ready=1.
  - Reset mid-operation discards all in-flight transactions; no partial result is emitted after reset releases.
- Simultaneous events: accept and emit in the same cycle is legal when out_ready=1. The pipe advances one stage.
- When out_valid=0, out holds the last S3 contents (0 after reset). Consumers must qualify out with out_valid.
- N=1 degenerates to C = A*B (+D) with the same 3-cycle latency.

Test Plan:
- N=2, WIDTH=32, out_ready=1: A=[[1,2],[3,4]], B=[[5,6],[7,8]], in_add_d=0 accepted on edge 0 -> out_valid=1 after edge 2, out=[[19,22],[43,50]], out_valid=0 on the following cycle.
- Bias: same A and B with in_add_d=1, D=[[1,1],[1,1]] -> out=[[20,23],[44,51]]. Follow immediately with in_add_d=0 and D=[[9,9],[9,9]] -> out=[[19,22],[43,50]] (D ignored).
- Wrap: A[0][0]=0xFFFFFFFF, A[0][1]=1, B[0][0]=2, B[1][0]=3, all other elements 0 -> out[0][0]=0x00000001; 0xFFFFFFFE+3 wraps; all other elements 0.
- Backpressure:
  - Stimulus: stream 5 distinct matrices with in_valid held high. Hold out_ready=0 from the cycle the first result appears for 4 cycles, then raise it.
  - Required: in_ready=0 while stalled with 3 in flight; out holds result #1 stably.
  - Required: all 5 results emerge in order, each exactly once, and none are lost or duplicated.
- Reset mid-flight:
  - Stimulus: accept 2 transactions, then assert rst asynchronously between edges.
  - Required: out_valid and out drop to 0 before the next edge.
  - Required: after release, no stale result ever appears and in_ready=1.
- N=3, WIDTH=16:
  - A = identity, B=[[1,2,3],[4,5,6],[7,8,9]] -> out = B.
  - A=all 0x0100, B=all 0x0100 -> every element 0x0000 (product 0x10000 truncated).
